// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NREQ byte producers.
// Define UART_ARB_FIXED_PRIORITY_EN to make the lowest valid index always win.
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 11,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic              clk_baud,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        bus_out,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              zero_drop
);

  // state | meaning
  // IDLE  | bus_out idle, req_ready offered to the current winner
  // HOLD  | accepted byte driven on bus_out
  // GAP   | bus_out forced to 0 while uart_tx shifts the frame out

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("uart_tx_arbiter: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("uart_tx_arbiter: GAP_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [7:0]     win_data;
  logic           xfer;

  // Later loop iterations override earlier ones, so scan from the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef UART_ARB_FIXED_PRIORITY_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && ((int'(ptr) + k) % NREQ) == i) begin
          win_found = 1'b1;
          win_idx   = IDW'(i);
        end
      end
    end
`endif
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) win_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rst && state == IDLE && win_found && win_idx == IDW'(i)) req_ready[i] = 1'b1;
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_ff @(posedge clk_baud) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= IDW'(NREQ - 1);
      cnt       <= '0;
      bus_out   <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      zero_drop <= 1'b0;
    end else begin
      zero_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            ptr      <= win_idx;
            grant_id <= win_idx;
            if (win_data != 8'h00) begin
              bus_out <= win_data;
              busy    <= 1'b1;
              cnt     <= CW'(HOLD_CYCLES - 1);
              state   <= HOLD;
            end else begin
              zero_drop <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            bus_out <= '0;
            cnt     <= CW'(GAP_CYCLES - 1);
            state   <= GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timeline model checked every cycle plus directed scenarios.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int HOLD = 2;
  localparam int GAP  = 11;
  localparam int IDW  = 2;
  localparam int SLOT = HOLD + GAP + 1;

  logic              clk_baud = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        bus_out;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              zero_drop;

  always #5 clk_baud = ~clk_baud;

  uart_tx_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk_baud (clk_baud),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .bus_out  (bus_out),
    .busy     (busy),
    .grant_id (grant_id),
    .zero_drop(zero_drop)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: everything follows from the edge of the last non-zero transfer.
  int             n_edge = 0;
  int             t_x = -1000;
  int             m_ptr = NREQ - 1;
  logic [IDW-1:0] m_gid = '0;
  logic           m_zd = 1'b0;
  logic [7:0]     m_byte = '0;
  bit             armed = 1'b0;
  int             g_edge[$];
  int             g_id[$];
  int             g_data[$];

  function automatic bit busy_at(int e);
    return (e - t_x >= 0) && (e - t_x < HOLD + GAP);
  endfunction

  function automatic int winner(int ptr, logic [NREQ-1:0] v);
`ifdef UART_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  initial begin
    int w;
    int k;
    logic [7:0] d;
    logic [NREQ-1:0] exp_rdy;
    forever begin
      @(posedge clk_baud);
      n_edge++;
      if (!rst) begin
        armed = 1'b1;
        t_x   = -1000;
        m_ptr = NREQ - 1;
        m_gid = '0;
        m_zd  = 1'b0;
      end else if (armed) begin
        m_zd = 1'b0;
        if (!busy_at(n_edge - 1)) begin
          w = winner(m_ptr, req_valid);
          if (w >= 0) begin
            d     = req_data[8*w +: 8];
            m_ptr = w;
            m_gid = IDW'(w);
            g_edge.push_back(n_edge);
            g_id.push_back(w);
            g_data.push_back(int'(d));
            if (d != 8'h00) begin
              t_x    = n_edge;
              m_byte = d;
            end else begin
              m_zd = 1'b1;
            end
          end
        end
      end
      #2;
      if (armed) begin
        k = n_edge - t_x;
        chk("m_bus_out", bus_out, (k >= 0 && k < HOLD) ? m_byte : 8'h00);
        chk("m_busy", busy, busy_at(n_edge));
        chk("m_grant_id", grant_id, m_gid);
        chk("m_zero_drop", zero_drop, m_zd);
      end
      @(negedge clk_baud);
      #3;
      if (armed) begin
        exp_rdy = '0;
        if (rst && !busy_at(n_edge)) begin
          w = winner(m_ptr, req_valid);
          if (w >= 0) exp_rdy[w] = 1'b1;
        end
        chk("m_req_ready", req_ready, exp_rdy);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk_baud);
    #1;
  endtask

  task automatic set_byte(int i, logic [7:0] d);
    req_data[8*i +: 8] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_id[5];
    int exp_dat[5];
`ifdef UART_ARB_FIXED_PRIORITY_EN
    exp_id  = '{0, 0, 0, 0, 0};
    exp_dat = '{'hA1, 'hA1, 'hA1, 'hA1, 'hA1};
`else
    exp_id  = '{0, 1, 2, 3, 0};
    exp_dat = '{'hA1, 'hA2, 'hA3, 'hA4, 'hA1};
`endif

    // Reset, then a single request from requester 0
    tick(3);
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_zero_drop", zero_drop, 1'b0);
    req_valid = 4'b0001;
    chk("rst_ready_low", req_ready, 4'b0000);
    rst = 1'b1;
    set_byte(0, 8'h55);
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick(1);
    chk("t1_bus_h1", bus_out, 8'h55);
    chk("t1_busy_h1", busy, 1'b1);
    chk("t1_gid", grant_id, 2'd0);
    req_valid = '0;
    tick(1);
    chk("t1_bus_h2", bus_out, 8'h55);
    tick(1);
    chk("t1_bus_gap", bus_out, 8'h00);
    chk("t1_busy_gap", busy, 1'b1);
    tick(10);
    chk("t1_busy_last", busy, 1'b1);
    tick(1);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_log_n", g_id.size(), 1);
    if (g_id.size() >= 1) chk("t1_log_data", g_data[0], 'h55);

    // All four requesters valid continuously
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    base = g_id.size();
    set_byte(0, 8'hA1); set_byte(1, 8'hA2); set_byte(2, 8'hA3); set_byte(3, 8'hA4);
    req_valid = 4'b1111;
    tick(1);
    chk("t2_bus_first", bus_out, 8'hA1);
    chk("t2_gid_first", grant_id, 2'd0);
    tick(SLOT);
    chk("t2_bus_second", bus_out, exp_dat[1]);
    chk("t2_gid_second", grant_id, exp_id[1]);
    tick(3 * SLOT);
    req_valid = '0;
    chk("t2_log_n", g_id.size() - base, 5);
    for (int j = 0; j < 5; j++) begin
      if (base + j < g_id.size()) begin
        chk("t2_order_id", g_id[base + j], exp_id[j]);
        chk("t2_order_data", g_data[base + j], exp_dat[j]);
        if (j > 0) chk("t2_spacing", g_edge[base + j] - g_edge[base + j - 1], SLOT);
      end
    end
    tick(SLOT);

    // Zero byte from requester 2 while requester 3 waits with 0xAA
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    set_byte(2, 8'h00);
    set_byte(3, 8'hAA);
    req_valid = 4'b1100;
    #1 chk("t3_ready_r2", req_ready, 4'b0100);
    tick(1);
    chk("t3_zero_drop", zero_drop, 1'b1);
    chk("t3_bus_idle", bus_out, 8'h00);
    chk("t3_busy_idle", busy, 1'b0);
    chk("t3_gid2", grant_id, 2'd2);
    req_valid = 4'b1000;
    #1 chk("t3_ready_r3", req_ready, 4'b1000);
    tick(1);
    chk("t3_zd_pulse_end", zero_drop, 1'b0);
    chk("t3_bus_aa1", bus_out, 8'hAA);
    chk("t3_gid3", grant_id, 2'd3);
    req_valid = '0;
    tick(1);
    chk("t3_bus_aa2", bus_out, 8'hAA);
    tick(1);
    chk("t3_bus_gap", bus_out, 8'h00);
    tick(11);
    chk("t3_idle", busy, 1'b0);

    // Reset during the second HOLD cycle
    set_byte(0, 8'h55);
    req_valid = 4'b0001;
    tick(1);
    chk("t4_bus_h1", bus_out, 8'h55);
    req_valid = '0;
    tick(1);
    chk("t4_bus_h2", bus_out, 8'h55);
    rst = 1'b0;
    tick(1);
    chk("t4_bus_abort", bus_out, 8'h00);
    chk("t4_busy_abort", busy, 1'b0);
    rst = 1'b1;
    set_byte(1, 8'h31);
    set_byte(2, 8'h32);
    req_valid = 4'b0110;
    #1 chk("t4_ready_low_idx", req_ready, 4'b0010);
    tick(1);
    chk("t4_bus_after", bus_out, 8'h31);
    chk("t4_gid_after", grant_id, 2'd1);
    req_valid = '0;
    tick(13);

    // Data change during GAP is ignored until a fresh handshake
    set_byte(1, 8'h10);
    req_valid = 4'b0010;
    tick(1);
    chk("t5_bus_10", bus_out, 8'h10);
    tick(2);
    set_byte(1, 8'h20);
    for (int i = 0; i < GAP; i++) begin
      chk("t5_gap_ready", req_ready, 4'b0000);
      chk("t5_gap_bus", bus_out, 8'h00);
      if (i == 3) begin
        req_valid[3] = 1'b1;
        set_byte(3, 8'h77);
      end
      if (i == 8) req_valid[3] = 1'b0;
      tick(1);
    end
    #1 chk("t5_ready_fresh", req_ready, 4'b0010);
    tick(1);
    chk("t5_bus_20", bus_out, 8'h20);
    chk("t5_gid", grant_id, 2'd1);
    req_valid = '0;
    tick(SLOT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
